// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter: FSM state encoding and
// default sizing constants used as parameter defaults by the top level.
package adder_share_arbiter_pkg;

  localparam int DEFAULT_ADDER_SIZE = 32;
  localparam int DEFAULT_NUM_REQ    = 4;

  // IDLE: arbitrate new sequences, EXEC: adder busy for one cycle,
  // RESP: result presented to the granted requester,
  // LOCK: mid-sequence, only the owning requester may send its next beat.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2,
    LOCK = 2'd3
  } state_t;

endpackage

// File: rtl/adder_share_arbiter_rr.sv
// Round-robin arbiter: picks the lowest-index active request at or after
// ptr, wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Scan candidates ptr, ptr+1, ... modulo NUM_REQ; first active one wins.
  always_comb begin
    logic [IDX_W:0] w_cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_any && req[w_cand[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = w_cand[IDX_W-1:0];
      end
    end
    if (grant_any) begin
      grant = NUM_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external combinational adder among NUM_REQ requesters.
// Each beat takes IDLE/LOCK (accept) -> EXEC (add) -> RESP (deliver).
// Multi-beat sequences (last=0) lock the adder to one requester and chain
// the carry-out of each beat into the next beat's carry-in.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int ADDER_SIZE = DEFAULT_ADDER_SIZE,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDER_SIZE-1:0] req_op1,
  input  logic [NUM_REQ*ADDER_SIZE-1:0] req_op2,
  input  logic [NUM_REQ-1:0]            req_cin,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ADDER_SIZE-1:0]         rsp_res,
  output logic                          rsp_cout,
  output logic [ADDER_SIZE-1:0]         add_op1,
  output logic [ADDER_SIZE-1:0]         add_op2,
  output logic                          add_cin,
  input  logic [ADDER_SIZE-1:0]         add_res,
  input  logic                          add_cout
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_grant;
  logic                  r_carry;
  logic                  r_op_cin;
  logic                  r_last;
  logic [ADDER_SIZE-1:0] r_op1;
  logic [ADDER_SIZE-1:0] r_op2;
  logic [ADDER_SIZE-1:0] r_res;
  logic                  r_res_cout;

  logic [NUM_REQ-1:0]    w_arb_grant;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_any;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_accept;
  logic                  w_rsp_hs;
  logic [ADDER_SIZE-1:0] w_sel_op1;
  logic [ADDER_SIZE-1:0] w_sel_op2;
  logic                  w_sel_cin;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx),
    .grant_any (w_arb_any)
  );

  assign w_owner_oh = NUM_REQ'(1) << r_grant;

  // In LOCK the owner is fixed; otherwise the arbiter chooses.
  assign w_sel_idx = (r_state == LOCK) ? r_grant : w_arb_idx;
  assign w_sel_op1 = req_op1[int'(w_sel_idx) * ADDER_SIZE +: ADDER_SIZE];
  assign w_sel_op2 = req_op2[int'(w_sel_idx) * ADDER_SIZE +: ADDER_SIZE];
  // A continuation beat takes the previous beat's carry, not its own cin.
  assign w_sel_cin = (r_state == LOCK) ? r_carry : req_cin[w_sel_idx];

  assign w_accept = ((r_state == IDLE) && w_arb_any) ||
                    ((r_state == LOCK) && req_valid[r_grant]);
  assign w_rsp_hs = (r_state == RESP) && rsp_ready[r_grant];

  // Accept strobe: only in IDLE/LOCK, and held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (r_state == IDLE) begin
        req_ready = w_arb_grant;
      end else if (r_state == LOCK) begin
        req_ready = w_owner_oh & req_valid;
      end
    end
  end

  // Response bus is only non-zero while presenting a result.
  always_comb begin
    rsp_valid = '0;
    rsp_res   = '0;
    rsp_cout  = 1'b0;
    if (r_state == RESP) begin
      rsp_valid = w_owner_oh;
      rsp_res   = r_res;
      rsp_cout  = r_res_cout;
    end
  end

  // Adder inputs come straight from registers so they never follow the
  // requester buses combinationally.
  assign add_op1 = r_op1;
  assign add_op2 = r_op2;
  assign add_cin = r_op_cin;

  // Main sequencer: accept, execute, respond, then release or stay locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_carry    <= 1'b0;
      r_op_cin   <= 1'b0;
      r_last     <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_res      <= '0;
      r_res_cout <= 1'b0;
    end else begin
      case (r_state)
        IDLE, LOCK: begin
          if (w_accept) begin
            r_op1    <= w_sel_op1;
            r_op2    <= w_sel_op2;
            r_op_cin <= w_sel_cin;
            r_last   <= req_last[w_sel_idx];
            r_grant  <= w_sel_idx;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_res      <= add_res;
          r_res_cout <= add_cout;
          r_state    <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_carry <= r_res_cout;
            if (r_last) begin
              r_rr_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
              r_state  <= IDLE;
            end else begin
              r_state  <= LOCK;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (ADDER_SIZE=32, NUM_REQ=4).
// A negedge monitor pushes expected sums on every accept and pops them on
// every response handshake; scenario tasks add their own targeted checks.
module tb_adder_share_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1 = '0;
  logic [N*W-1:0] req_op2 = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_res;
  logic           rsp_cout;
  logic [W-1:0]   add_op1;
  logic [W-1:0]   add_op2;
  logic           add_cin;
  logic [W-1:0]   add_res;
  logic           add_cout;

  always #5 clk = ~clk;

  adder_share_arbiter #(.ADDER_SIZE(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_cout  (rsp_cout),
    .add_op1   (add_op1),
    .add_op2   (add_op2),
    .add_cin   (add_cin),
    .add_res   (add_res),
    .add_cout  (add_cout)
  );

  // External combinational adder.
  assign {add_cout, add_res} = 33'(add_op1) + 33'(add_op2) + 33'(add_cin);

  typedef struct {
    int         idx;
    logic [W-1:0] res;
    logic       cout;
    logic       last;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   m_lock   = -1;
  logic m_carry  = 1'b0;
  bit   head_seen = 1'b0;
  exp_t m_e;
  logic [W:0] m_sum;
  logic m_cin;

  always @(posedge clk) cyc++;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_lock    = -1;
      m_carry   = 1'b0;
      head_seen = 1'b0;
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_spurious_rsp rsp_valid=%b required none", rsp_valid);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            n_checks++;
            if (cyc !== sb[0].acc_cyc + 2)
              $display("FAIL sb_latency rsp at cycle %0d required %0d", cyc, sb[0].acc_cyc + 2);
            else n_pass++;
            n_checks++;
            if (rsp_valid !== 4'(1 << sb[0].idx))
              $display("FAIL sb_rsp_valid got=%b required=%b", rsp_valid, 4'(1 << sb[0].idx));
            else n_pass++;
          end
          if ((rsp_valid & rsp_ready) != '0) begin
            m_e = sb.pop_front();
            n_checks++;
            if (rsp_res !== m_e.res || rsp_cout !== m_e.cout)
              $display("FAIL sb_result req%0d got res=%h cout=%b required res=%h cout=%b",
                       m_e.idx, rsp_res, rsp_cout, m_e.res, m_e.cout);
            else n_pass++;
            m_carry   = m_e.cout;
            m_lock    = m_e.last ? -1 : m_e.idx;
            head_seen = 1'b0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (m_lock >= 0) begin
            n_checks++;
            if (i != m_lock)
              $display("FAIL sb_lock_violation granted=%0d required=%0d", i, m_lock);
            else n_pass++;
          end
          m_cin = (m_lock == i) ? m_carry : req_cin[i];
          m_sum = {1'b0, req_op1[i*W +: W]} + {1'b0, req_op2[i*W +: W]} + 33'(m_cin);
          m_e.idx     = i;
          m_e.res     = m_sum[W-1:0];
          m_e.cout    = m_sum[W];
          m_e.last    = req_last[i];
          m_e.acc_cyc = cyc;
          sb.push_back(m_e);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic last);
    req_op1[i*W +: W] = a;
    req_op2[i*W +: W] = b;
    req_cin[i]        = cin;
    req_last[i]       = last;
  endtask

  task automatic reset_dut;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'hDEAD_0000 + W'(i), 32'h1234_5678, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b required=0000", req_ready);
    else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_cout, rsp_res} !== '0)
      $display("FAIL reset_rsp got valid=%b cout=%b res=%h required all zero", rsp_valid, rsp_cout, rsp_res);
    else n_pass++;
    n_checks++;
    if ({add_op1, add_op2, add_cin} !== '0)
      $display("FAIL reset_add got op1=%h op2=%h cin=%b required all zero", add_op1, add_op2, add_cin);
    else n_pass++;
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000)
      $display("FAIL reset_idle got ready=%b valid=%b required 0000/0000", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_single_add;
    bit found = 1'b0;
    @(posedge clk); #1;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    rsp_ready = '1;
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found || req_ready !== 4'b0001)
      $display("FAIL single_grant got ready=%b required 0001", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000)
      $display("FAIL single_exec_idle got ready=%b valid=%b required 0000/0000", req_ready, rsp_valid);
    else n_pass++;
    n_checks++;
    if (add_op1 !== 32'hFFFF_FFFF || add_op2 !== 32'h0000_0001 || add_cin !== 1'b0)
      $display("FAIL single_add_inputs got %h+%h+%b required ffffffff+00000001+0", add_op1, add_op2, add_cin);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0001 || rsp_res !== 32'h0 || rsp_cout !== 1'b1)
      $display("FAIL single_rsp got valid=%b res=%h cout=%b required 0001/00000000/1", rsp_valid, rsp_res, rsp_cout);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0000 || rsp_res !== 32'h0 || rsp_cout !== 1'b0)
      $display("FAIL single_rsp_clear got valid=%b res=%h cout=%b required zero", rsp_valid, rsp_res, rsp_cout);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    int g_idx[$];
    int g_cyc[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < N; i++)
      set_req(i, 32'(i + 1) * 32'h1000_0000 + 32'(i), 32'h0F0F_0000 ^ 32'(i), 1'(i & 1), 1'b1);
    rsp_ready = '1;
    req_valid = '1;
    for (int k = 0; k < 30 && g_idx.size() < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
    end
    @(posedge clk); #1 req_valid = '0;
    n_checks++;
    if (g_idx.size() != 5) $display("FAIL rr_grant_count got=%0d required=5", g_idx.size());
    else n_pass++;
    for (int k = 0; k < g_idx.size() && k < 5; k++) begin
      n_checks++;
      if (g_idx[k] != exp_order[k])
        $display("FAIL rr_order grant#%0d got=%0d required=%0d", k, g_idx[k], exp_order[k]);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (g_cyc[k] - g_cyc[k-1] != 3)
          $display("FAIL rr_spacing grant#%0d got=%0d cycles required=3", k, g_cyc[k] - g_cyc[k-1]);
        else n_pass++;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_chain;
    int beats = 0;
    int rsp1 = 0;
    int rsp1_cyc = -1;
    int g2_cyc = -1;
    logic [W-1:0] exp_res[2]  = '{32'h0000_0000, 32'h0000_0001};
    logic         exp_cout[2] = '{1'b1, 1'b0};
    reset_dut();
    set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    set_req(2, 32'h0000_00AA, 32'h0000_0055, 1'b1, 1'b1);
    rsp_ready = '1;
    req_valid = 4'b0110;
    for (int k = 0; k < 40 && g2_cyc < 0; k++) begin
      @(negedge clk);
      if (rsp_valid[1] && rsp_ready[1] && rsp1 < 2) begin
        n_checks++;
        if (rsp_res !== exp_res[rsp1] || rsp_cout !== exp_cout[rsp1])
          $display("FAIL chain_beat%0d got res=%h cout=%b required res=%h cout=%b",
                   rsp1, rsp_res, rsp_cout, exp_res[rsp1], exp_cout[rsp1]);
        else n_pass++;
        rsp1++;
        if (rsp1 == 2) rsp1_cyc = cyc;
      end
      if (req_ready[2]) g2_cyc = cyc;
      if (req_ready[1]) begin
        beats++;
        @(posedge clk); #1;
        if (beats == 1) set_req(1, 32'h0, 32'h0, 1'b0, 1'b1);
        else req_valid[1] = 1'b0;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    n_checks++;
    if (rsp1 != 2) $display("FAIL chain_rsp_count got=%0d required=2", rsp1);
    else n_pass++;
    n_checks++;
    if (rsp1_cyc < 0 || g2_cyc <= rsp1_cyc)
      $display("FAIL chain_req2_wait req2 grant cycle=%0d required after %0d", g2_cyc, rsp1_cyc);
    else n_pass++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_pressure;
    bit found = 1'b0;
    @(posedge clk); #1;
    set_req(3, 32'hF000_0000, 32'h2000_0000, 1'b1, 1'b1);
    rsp_ready = 4'b0111;
    req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[3]) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL bp_grant got ready=%b required 1000", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b1000 || rsp_res !== 32'h1000_0001 || rsp_cout !== 1'b1)
        $display("FAIL bp_hold cyc%0d got valid=%b res=%h cout=%b required 1000/10000001/1",
                 k, rsp_valid, rsp_res, rsp_cout);
      else n_pass++;
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL bp_no_ready cyc%0d got=%b required=0000", k, req_ready);
      else n_pass++;
      @(posedge clk); #1;
      rsp_ready = (k % 2 == 0) ? 4'b0000 : 4'b0111;
    end
    rsp_ready = '1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL bp_next_grant got ready=%b required 0001", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_in_lock;
    bit found = 1'b0;
    @(posedge clk); #1;
    rsp_ready = '1;
    set_req(2, 32'h7, 32'h8, 1'b0, 1'b1);
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[2]) begin found = 1'b1; break; end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 32'h1, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin found = found & 1'b1; break; end
    end
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) break;
    end
    @(posedge clk); #1;
    set_req(3, 32'h9, 32'h9, 1'b0, 1'b1);
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (!found || req_ready !== 4'b0000)
      $display("FAIL lock_blocks_others got ready=%b required 0000", req_ready);
    else n_pass++;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_res !== '0 || rsp_cout !== 1'b0)
      $display("FAIL rst_lock_outputs got ready=%b valid=%b res=%h cout=%b required zero",
               req_ready, rsp_valid, rsp_res, rsp_cout);
    else n_pass++;
    n_checks++;
    if ({add_op1, add_op2, add_cin} !== '0)
      $display("FAIL rst_lock_add got op1=%h op2=%h cin=%b required zero", add_op1, add_op2, add_cin);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1, 32'h5, 32'h6, 1'b1, 1'b1);
    req_valid = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL rst_next_grant got=%b required=0010", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_res !== 32'hC || rsp_cout !== 1'b0)
      $display("FAIL rst_cin_used got valid=%b res=%h cout=%b required 0010/0000000c/0",
               rsp_valid, rsp_res, rsp_cout);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[3]) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) $display("FAIL rst_req3_grant got ready=%b required 1000", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_chain();
    test_back_pressure();
    test_reset_in_lock();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drained got=%0d pending required=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter ADDER_SIZE, default 32, operand/result width in bits (power of two, >=8).
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have ports clk, input, 1, single clock (all logic on rising edge); rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req_valid, input, NUM_REQ, per-requester beat valid; req_ready, output, NUM_REQ, one-hot accept.
REQ-005 SHALL have ports req_op1 and req_op2, input, NUM_REQ*ADDER_SIZE, packed operands (requester i at [i*ADDER_SIZE +: ADDER_SIZE]).
REQ-006 SHALL have ports req_cin, input, NUM_REQ, carry-in for a sequence's first beat; req_last, input, NUM_REQ, 1 = final beat of sequence.
REQ-007 SHALL have ports rsp_valid, output, NUM_REQ, one-hot result valid; rsp_ready, input, NUM_REQ, result accept; rsp_res, output, ADDER_SIZE, shared result bus; rsp_cout, output, 1, shared carry-out.
REQ-008 SHALL have ports add_op1, output, ADDER_SIZE; add_op2, output, ADDER_SIZE; add_cin, output, 1; add_res, input, ADDER_SIZE; add_cout, input, 1 -- the shared external combinational adder.

Function
REQ-009 SHALL implement FSM states IDLE, EXEC, RESP, LOCK.
REQ-010 In IDLE, SHALL grant the lowest-index valid requester at or after rr_ptr (round-robin, wrap NUM_REQ-1 -> 0), drive req_ready one-hot for it combinationally, and register op1, op2, cin, last, grant on valid&ready, then go to EXEC.
REQ-011 req_ready SHALL be all-zero in EXEC and RESP.
REQ-012 In EXEC (exactly one cycle), SHALL drive add_op1/op2/cin from registers, capture add_res/add_cout into result registers, and go to RESP.
REQ-013 add_* outputs SHALL be driven from registers at all times (zero when idle since reset) so the adder input never glitches from requester buses.
REQ-014 In RESP, SHALL assert rsp_valid[grant] only; rsp_res/rsp_cout SHALL hold stable until rsp_ready[grant]; rsp_ready of other requesters SHALL be ignored.
REQ-015 On response handshake: if last=1, SHALL advance rr_ptr to grant+1 (wrap) and go to IDLE; if last=0, SHALL go to LOCK.
REQ-016 In LOCK, SHALL assert req_ready only for the locked requester when valid; other requesters SHALL not be granted; accepted beat SHALL use the stored carry-out as cin (req_cin ignored), then EXEC.
REQ-017 Latency: accept cycle N -> rsp_valid high from cycle N+2; minimum 3 cycles per beat.
REQ-018 rsp_valid, rsp_res, rsp_cout SHALL be zero whenever not in RESP.
REQ-019 No lock timeout: a locked requester deasserting req_valid SHALL stall the arbiter in LOCK indefinitely.

Reset
REQ-020 rst SHALL asynchronously force state IDLE, rr_ptr 0, lock cleared, stored carry 0, all operand/result registers 0, req_ready/rsp_valid 0.
REQ-021 Reset mid-sequence SHALL discard the in-flight beat without emitting a response.

Structure
REQ-022 Shared package SHALL hold the FSM state enum (IDLE/EXEC/RESP/LOCK) and default ADDER_SIZE/NUM_REQ constants.
REQ-023 SHALL contain one sub-module rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant + index); adder is external.

Verification (ADDER_SIZE=32, NUM_REQ=4)
REQ-024 req0 op1=0xFFFF_FFFF op2=0x0000_0001 cin=0 last=1 -> rsp_valid[0] two cycles after accept, rsp_res=0x0000_0000, rsp_cout=1.
REQ-025 All four valid continuously, last=1, rsp_ready=1, from reset -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-026 req1 64-bit chain: beat {0xFFFF_FFFF+0x0000_0001, cin=0, last=0} then {0x0+0x0, last=1}, req2 valid throughout -> res 0x0/cout 1, then res 0x0000_0001/cout 0; req2 granted only after second response.
REQ-027 rsp_ready[3] low 5 cycles during RESP -> rsp_res/rsp_cout stable, no req_ready asserted, rsp_ready[0..2] pulses ignored.
REQ-028 rst asserted in LOCK mid-chain -> all outputs 0 same cycle, next grant after release follows rr_ptr=0 with req_cin used.
